// File: rtl/decode_stage_pkg.sv
// ============================================================================
// Module   : decode_stage_pkg
// Brief    : Shared control constants: instruction fields, opcodes, formats.
// Revision : 1.0
// ============================================================================
`default_nettype none

package decode_stage_pkg;

    // Instruction field positions
    localparam int c_opcode_lsb = 0;
    localparam int c_rd_lsb     = 7;
    localparam int c_funct3_lsb = 12;
    localparam int c_rs1_lsb    = 15;
    localparam int c_rs2_lsb    = 20;
    localparam int c_funct7_lsb = 25;

    localparam logic [6:0] c_opc_lui       = 7'b0110111;
    localparam logic [6:0] c_opc_auipc     = 7'b0010111;
    localparam logic [6:0] c_opc_jal       = 7'b1101111;
    localparam logic [6:0] c_opc_jalr      = 7'b1100111;
    localparam logic [6:0] c_opc_branch    = 7'b1100011;
    localparam logic [6:0] c_opc_load      = 7'b0000011;
    localparam logic [6:0] c_opc_store     = 7'b0100011;
    localparam logic [6:0] c_opc_op_imm    = 7'b0010011;
    localparam logic [6:0] c_opc_op        = 7'b0110011;
    localparam logic [6:0] c_opc_misc_mem  = 7'b0001111;
    localparam logic [6:0] c_opc_system    = 7'b1110011;
    localparam logic [6:0] c_opc_op_imm_32 = 7'b0011011;
    localparam logic [6:0] c_opc_op_32     = 7'b0111011;

    typedef enum logic [2:0] {
        c_fmt_r = 3'd0,
        c_fmt_i = 3'd1,
        c_fmt_s = 3'd2,
        c_fmt_b = 3'd3,
        c_fmt_u = 3'd4,
        c_fmt_j = 3'd5
    } fmt_e;

endpackage

`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
// ============================================================================
// Module   : imm_gen
// Brief    : Combinational immediate generator, sign-extended to XLEN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imm_gen
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_inst,
    input  fmt_e            i_fmt,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_fmt)
            c_fmt_i: w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            c_fmt_s: w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            c_fmt_b: w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7],
                                i_inst[30:25], i_inst[11:8], 1'b0};
            c_fmt_u: w_imm32 = {i_inst[31:12], 12'b0};
            c_fmt_j: w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12],
                                i_inst[20], i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Every format fits in 32 bits, so widening is a plain sign extension
    assign o_imm = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Brief    : Registered RV32/RV64 decode with a two-entry skid buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic            out_rd_we,
    output logic            out_rs1_used,
    output logic            out_rs2_used
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      fmt;
        logic            illegal;
        logic            rd_we;
        logic            rs1_used;
        logic            rs2_used;
    } entry_t;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [4:0]      w_rd;
    fmt_e            w_fmt;
    logic            w_legal;
    logic            w_rd_we;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic [XLEN-1:0] w_imm;
    entry_t          w_entry;

    assign w_opcode = in_inst[c_opcode_lsb +: 7];
    assign w_funct3 = in_inst[c_funct3_lsb +: 3];
    assign w_rd     = in_inst[c_rd_lsb +: 5];

    always_comb begin
        w_fmt      = c_fmt_r;
        w_legal    = 1'b1;
        w_rd_we    = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            c_opc_lui, c_opc_auipc: begin
                w_fmt = c_fmt_u; w_rd_we = 1'b1;
            end
            c_opc_jal: begin
                w_fmt = c_fmt_j; w_rd_we = 1'b1;
            end
            c_opc_jalr: begin
                w_fmt = c_fmt_i; w_rd_we = 1'b1; w_rs1_used = 1'b1;
                w_legal = (w_funct3 == 3'b000);
            end
            c_opc_branch: begin
                w_fmt = c_fmt_b; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            c_opc_load, c_opc_op_imm: begin
                w_fmt = c_fmt_i; w_rd_we = 1'b1; w_rs1_used = 1'b1;
            end
            c_opc_store: begin
                w_fmt = c_fmt_s; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
            end
            c_opc_op: begin
                w_rd_we = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
            end
            c_opc_misc_mem: w_fmt = c_fmt_i;
            c_opc_system: begin
                w_fmt      = c_fmt_i;
                w_rd_we    = (w_funct3 != 3'b000);
                w_rs1_used = (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                             (w_funct3 == 3'b011);
            end
            c_opc_op_imm_32: begin
                w_fmt = c_fmt_i; w_rd_we = 1'b1; w_rs1_used = 1'b1;
                w_legal = (XLEN == 64);
            end
            c_opc_op_32: begin
                w_rd_we = 1'b1; w_rs1_used = 1'b1; w_rs2_used = 1'b1;
                w_legal = (XLEN == 64);
            end
            default: w_legal = 1'b0;
        endcase
        if (w_opcode[1:0] != 2'b11) w_legal = 1'b0;
        // Illegal encodings look like an inert R-format with no register traffic
        if (!w_legal) begin
            w_fmt      = c_fmt_r;
            w_rd_we    = 1'b0;
            w_rs1_used = 1'b0;
            w_rs2_used = 1'b0;
        end
        if (w_rd == 5'd0) w_rd_we = 1'b0;
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_inst (in_inst),
        .i_fmt  (w_fmt),
        .o_imm  (w_imm)
    );

    always_comb begin
        w_entry          = '0;
        w_entry.pc       = in_pc;
        w_entry.imm      = w_imm;
        w_entry.opcode   = w_opcode;
        w_entry.funct3   = w_funct3;
        w_entry.funct7   = in_inst[c_funct7_lsb +: 7];
        w_entry.rd       = w_rd;
        w_entry.rs1      = in_inst[c_rs1_lsb +: 5];
        w_entry.rs2      = in_inst[c_rs2_lsb +: 5];
        w_entry.fmt      = w_fmt;
        w_entry.illegal  = !w_legal;
        w_entry.rd_we    = w_rd_we;
        w_entry.rs1_used = w_rs1_used;
        w_entry.rs2_used = w_rs2_used;
    end

    entry_t r_main;
    entry_t r_skid;
    logic   r_main_valid;
    logic   r_skid_valid;
    logic   w_in_xfer;
    logic   w_out_xfer;

    assign w_in_xfer  = in_valid && !r_skid_valid;
    assign w_out_xfer = r_main_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_xfer) begin
            // Skid valid implies in_ready was low, so no input can collide here
            if (r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main       <= w_entry;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            if (!r_main_valid) begin
                r_main       <= w_entry;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_entry;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready     = !r_skid_valid;
    assign out_valid    = r_main_valid;
    assign out_pc       = r_main.pc;
    assign out_opcode   = r_main.opcode;
    assign out_funct3   = r_main.funct3;
    assign out_funct7   = r_main.funct7;
    assign out_rd       = r_main.rd;
    assign out_rs1      = r_main.rs1;
    assign out_rs2      = r_main.rs2;
    assign out_imm      = r_main.imm;
    assign out_fmt      = r_main.fmt;
    assign out_illegal  = r_main.illegal;
    assign out_rd_we    = r_main.rd_we;
    assign out_rs1_used = r_main.rs1_used;
    assign out_rs2_used = r_main.rs2_used;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench for decode_stage with a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc, out_pc, out_imm;
    logic [6:0]      out_opcode, out_funct7;
    logic [2:0]      out_funct3, out_fmt;
    logic [4:0]      out_rd, out_rs1, out_rs2;
    logic            out_illegal, out_rd_we, out_rs1_used, out_rs2_used;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_rd_we(out_rd_we),
        .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used)
    );

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [31:0]     inst;
        logic [2:0]      fmt;
        bit              ill, rdwe, rs1u, rs2u;
    } exp_t;

    exp_t            q[$];
    logic [XLEN-1:0] seen[$];
    int              n_chk = 0;
    int              n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference decode built directly from the ISA field rules
    function automatic exp_t model(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        exp_t   e;
        longint s, imm;
        bit     ok;
        logic [6:0] op;
        logic [2:0] f3;
        op  = inst[6:0];
        f3  = inst[14:12];
        s   = longint'($signed(inst));
        imm = 0;
        ok  = 1;
        e.pc = pc; e.inst = inst; e.fmt = 0;
        e.rdwe = 0; e.rs1u = 0; e.rs2u = 0;
        case (op)
            7'b0110111, 7'b0010111: begin e.fmt = 4; imm = s & ~longint'(12'hFFF); e.rdwe = 1; end
            7'b1101111: begin
                e.fmt = 5; e.rdwe = 1;
                imm = ((s >>> 31) << 20) | (longint'(inst[19:12]) << 12) |
                      (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
            end
            7'b1100111: begin e.fmt = 1; imm = s >>> 20; e.rdwe = 1; e.rs1u = 1; ok = (f3 == 0); end
            7'b1100011: begin
                e.fmt = 3; e.rs1u = 1; e.rs2u = 1; ok = (f3 != 2 && f3 != 3);
                imm = ((s >>> 31) << 12) | (longint'(inst[7]) << 11) |
                      (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
            end
            7'b0000011, 7'b0010011: begin e.fmt = 1; imm = s >>> 20; e.rdwe = 1; e.rs1u = 1; end
            7'b0100011: begin
                e.fmt = 2; e.rs1u = 1; e.rs2u = 1;
                imm = ((s >>> 25) << 5) | longint'(inst[11:7]);
            end
            7'b0110011: begin e.rdwe = 1; e.rs1u = 1; e.rs2u = 1; end
            7'b0001111: begin e.fmt = 1; imm = s >>> 20; end
            7'b1110011: begin
                e.fmt = 1; imm = s >>> 20; e.rdwe = (f3 != 0); e.rs1u = (f3 >= 1 && f3 <= 3);
            end
            7'b0011011: begin e.fmt = 1; imm = s >>> 20; e.rdwe = 1; e.rs1u = 1; ok = (XLEN == 64); end
            7'b0111011: begin e.rdwe = 1; e.rs1u = 1; e.rs2u = 1; ok = (XLEN == 64); end
            default: ok = 0;
        endcase
        if (!ok) begin
            e.fmt = 0; imm = 0; e.rdwe = 0; e.rs1u = 0; e.rs2u = 0;
        end
        if (inst[11:7] == 0) e.rdwe = 0;
        e.ill = !ok;
        e.imm = imm[XLEN-1:0];
        return e;
    endfunction

    task automatic compare(input exp_t e);
        chk("pc", out_pc, e.pc);
        chk("imm", out_imm, e.imm);
        chk("fmt", out_fmt, e.fmt);
        chk("illegal", out_illegal, e.ill);
        chk("rd_we", out_rd_we, e.rdwe);
        chk("rs1_used", out_rs1_used, e.rs1u);
        chk("rs2_used", out_rs2_used, e.rs2u);
        chk("opcode", out_opcode, e.inst[6:0]);
        chk("funct3", out_funct3, e.inst[14:12]);
        chk("funct7", out_funct7, e.inst[31:25]);
        chk("rd", out_rd, e.inst[11:7]);
        chk("rs1", out_rs1, e.inst[19:15]);
        chk("rs2", out_rs2, e.inst[24:20]);
    endtask

    // One clock: check at negedge, advance the model at posedge, return at posedge+1
    task automatic cycle();
        bit ox, ix;
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) compare(q[0]);
        ox = (q.size() > 0) && out_ready;
        ix = in_valid && (q.size() < 2);
        if (ox && !flush) seen.push_back(out_pc);
        @(posedge clk);
        if (flush) q.delete();
        else begin
            if (ox) void'(q.pop_front());
            if (ix) q.push_back(model(in_inst, in_pc));
        end
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [XLEN-1:0] pc);
        in_valid = 1'b1; in_inst = inst; in_pc = pc;
        cycle();
        in_valid = 1'b0;
    endtask

    logic [6:0] ops [13] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                             7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                             7'b0110011, 7'b0001111, 7'b1110011, 7'b0011011,
                             7'b0111011};

    initial begin
        logic [31:0] r;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm", out_imm, 0);
        chk("rst_fmt", out_fmt, 0);
        chk("rst_illegal", out_illegal, 0);
        chk("rst_pc", out_pc, 0);
        #4 rst = 1'b0;
        @(posedge clk); #1;

        out_ready = 1'b1;
        send(32'hFFF00093, 'h100);
        chk("addi_fmt", out_fmt, 1);
        chk("addi_imm", out_imm, 32'hFFFF_FFFF);
        chk("addi_rd", out_rd, 1);
        chk("addi_rd_we", out_rd_we, 1);
        chk("addi_rs1u", out_rs1_used, 1);
        chk("addi_rs2u", out_rs2_used, 0);
        cycle();

        send(32'h0020A423, 'h104);
        chk("sw_fmt", out_fmt, 2);
        chk("sw_imm", out_imm, 8);
        chk("sw_rd_we", out_rd_we, 0);
        chk("sw_rs2u", out_rs2_used, 1);
        cycle();

        in_valid = 1'b1; in_inst = 32'hFE000EE3; in_pc = 'h200;
        cycle();
        chk("beq_fmt", out_fmt, 3);
        chk("beq_imm", out_imm, 32'hFFFF_FFFC);
        in_inst = 32'h123452B7; in_pc = 'h204;
        cycle();
        in_valid = 1'b0;
        chk("lui_fmt", out_fmt, 4);
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd_we", out_rd_we, 1);
        cycle();

        // Skid fill and ordered drain
        out_ready = 1'b0; seen.delete();
        in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 'h0;
        cycle();
        in_pc = 'h4;
        cycle();
        chk("skid_in_ready_low", in_ready, 0);
        in_pc = 'h8;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 3 && in_valid; i++) begin
            cycle();
            if (in_ready) begin cycle(); in_valid = 1'b0; end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        chk("skid_count", seen.size(), 3);
        for (int i = 0; i < 3 && i < seen.size(); i++) chk("skid_order", seen[i], i * 4);

        send(32'h00000000, 'h300);
        chk("zero_illegal", out_illegal, 1);
        chk("zero_rd_we", out_rd_we, 0);
        chk("zero_imm", out_imm, 0);
        send(32'h0000706F, 'h304);
        chk("jal_illegal", out_illegal, 0);
        cycle();

        // Flush from FULL with a concurrent input
        out_ready = 1'b0;
        send(32'h00100093, 'h400);
        send(32'h00200113, 'h404);
        flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 'h408;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        cycle(); cycle();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        send(32'h00100093, 'h500);
        send(32'h00200113, 'h504);
        in_valid = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_valid", out_valid, 0);
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 3000; n++) begin
            r = $urandom;
            in_inst   = ($urandom_range(9) == 0) ? r : {r[31:7], ops[$urandom_range(12)]};
            in_pc     = XLEN'($urandom) & ~XLEN'(3);
            in_valid  = ($urandom_range(9) < 7);
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(99) < 3);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
